// File: rtl/width_reducer_rnd.sv
// Signed fixed-point width reducer: arithmetic right shift with selectable
// rounding, optional saturation, two-stage valid/ready pipeline and an
// overflow event counter.
module width_reducer_rnd #(
    parameter int unsigned IN_W   = 53,
    parameter int unsigned OUT_W  = 16,
    parameter int unsigned SHIFT  = 38,
    parameter int unsigned SAT_EN = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [IN_W-1:0]   data_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [1:0]        mode_i,
    output logic [OUT_W-1:0]  data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              ovf_o,
    input  logic              clr_i,
    output logic [CNT_W-1:0]  sat_cnt_o
);

    // Width of the shifted quotient plus one guard bit so rounding never wraps.
    localparam int unsigned QW = IN_W - SHIFT + 1;

    localparam logic [1:0] MODE_TRUNC = 2'd0;
    localparam logic [1:0] MODE_HUP   = 2'd1;
    localparam logic [1:0] MODE_CONV  = 2'd2;
    localparam logic [1:0] MODE_HAWAY = 2'd3;

    logic              s1_valid_q, s1_valid_d;
    logic [QW-1:0]     s1_r_q, s1_r_d;
    logic              valid_q, valid_d;
    logic [OUT_W-1:0]  data_q, data_d;
    logic              ovf_q, ovf_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              adv;
    logic [QW-1:0]     q_ext;
    logic              half_bit;
    logic              sticky;
    logic              sign_bit;
    logic              inc;
    logic [QW-1:0]     r_c;
    logic [OUT_W-1:0]  res_c;
    logic              rovf_c;
    logic              cnt_evt;

    // Whole pipeline moves together whenever the output register is free.
    assign adv     = ~valid_q | ready_i;
    assign ready_o = adv;

    // Stage-1 rounding: floor quotient plus a mode-dependent increment.
    always_comb begin
        q_ext    = {data_i[IN_W-1], data_i[IN_W-1:SHIFT]};
        half_bit = data_i[SHIFT-1];
        sticky   = |data_i[SHIFT-2:0];
        sign_bit = data_i[IN_W-1];
        inc      = 1'b0;
        case (mode_i)
            MODE_TRUNC: inc = 1'b0;
            MODE_HUP:   inc = half_bit;
            MODE_CONV:  inc = half_bit & (sticky | q_ext[0]);
            MODE_HAWAY: inc = half_bit & (sticky | ~sign_bit);
            default:    inc = 1'b0;
        endcase
        r_c = q_ext + QW'(inc);
    end

    // Stage-2 range reduction to OUT_W bits.
    generate
        if (QW <= OUT_W) begin : g_ext
            assign res_c  = OUT_W'($signed(s1_r_q));
            assign rovf_c = 1'b0;
        end else begin : g_red
            logic [QW-OUT_W:0] top_bits;
            logic              out_rng;
            assign top_bits = s1_r_q[QW-1:OUT_W-1];
            assign out_rng  = ~(&top_bits | ~|top_bits);
            assign rovf_c   = out_rng;
            if (SAT_EN != 0) begin : g_sat
                assign res_c = !out_rng        ? s1_r_q[OUT_W-1:0] :
                               s1_r_q[QW-1]    ? {1'b1, {(OUT_W-1){1'b0}}} :
                                                 {1'b0, {(OUT_W-1){1'b1}}};
            end else begin : g_wrap
                assign res_c = s1_r_q[OUT_W-1:0];
            end
        end
    endgenerate

    // Next-state for both pipeline stages and the overflow counter.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_r_d     = s1_r_q;
        valid_d    = valid_q;
        data_d     = data_q;
        ovf_d      = ovf_q;
        cnt_d      = cnt_q;
        cnt_evt    = valid_q & ready_i & ovf_q;

        if (adv) begin
            s1_valid_d = valid_i;
            if (valid_i) begin
                s1_r_d = r_c;
            end
            valid_d = s1_valid_q;
            if (s1_valid_q) begin
                data_d = res_c;
                ovf_d  = rovf_c;
            end
        end

        if (clr_i) begin
            cnt_d = CNT_W'(cnt_evt);
        end else if (cnt_evt && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State registers; reset discards everything in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid_q <= 1'b0;
            s1_r_q     <= '0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            ovf_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_r_q     <= s1_r_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            ovf_q      <= ovf_d;
            cnt_q      <= cnt_d;
        end
    end

    assign valid_o   = valid_q;
    assign data_o    = data_q;
    assign ovf_o     = ovf_q;
    assign sat_cnt_o = cnt_q;

endmodule

// File: tb/tb_width_reducer_rnd.sv
// Directed bench for width_reducer_rnd: a wide saturating build, a wide
// wrapping build with a 2-bit counter, and the default-parameter build.
module tb_width_reducer_rnd;

    logic               clk_i = 1'b0;
    logic               rst_i;
    logic signed [55:0] data_i;
    logic               valid_i;
    logic [1:0]         mode_i;
    logic               ready_i;
    logic               clr_i;

    logic               ready_a, valid_a, ovf_a;
    logic signed [15:0] data_a;
    logic [15:0]        cnt_a;
    logic               ready_b, valid_b, ovf_b;
    logic signed [15:0] data_b;
    logic [1:0]         cnt_b;
    logic               ready_c, valid_c, ovf_c;
    logic signed [15:0] data_c;
    logic [15:0]        cnt_c;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_i = ~clk_i;

    width_reducer_rnd #(.IN_W(56), .OUT_W(16), .SHIFT(38), .SAT_EN(1), .CNT_W(16)) dut_a (
        .clk_i(clk_i), .rst_i(rst_i), .data_i(data_i), .valid_i(valid_i), .ready_o(ready_a),
        .mode_i(mode_i), .data_o(data_a), .valid_o(valid_a), .ready_i(ready_i), .ovf_o(ovf_a),
        .clr_i(clr_i), .sat_cnt_o(cnt_a));

    width_reducer_rnd #(.IN_W(56), .OUT_W(16), .SHIFT(38), .SAT_EN(0), .CNT_W(2)) dut_b (
        .clk_i(clk_i), .rst_i(rst_i), .data_i(data_i), .valid_i(valid_i), .ready_o(ready_b),
        .mode_i(mode_i), .data_o(data_b), .valid_o(valid_b), .ready_i(ready_i), .ovf_o(ovf_b),
        .clr_i(clr_i), .sat_cnt_o(cnt_b));

    width_reducer_rnd dut_c (
        .clk_i(clk_i), .rst_i(rst_i), .data_i(data_i[52:0]), .valid_i(valid_i), .ready_o(ready_c),
        .mode_i(mode_i), .data_o(data_c), .valid_o(valid_c), .ready_i(ready_i), .ovf_o(ovf_c),
        .clr_i(clr_i), .sat_cnt_o(cnt_c));

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic signed [55:0] mk(input longint m, input int sh);
        return 56'(m <<< sh);
    endfunction

    // One isolated beat with ready_i high; result must appear two edges later.
    task automatic run_beat(input string tag, input logic signed [55:0] d, input logic [1:0] m,
                            input longint ea, input bit oa, input longint eb, input bit ob,
                            input bit chkc, input longint ec);
        @(negedge clk_i);
        data_i = d; mode_i = m; valid_i = 1'b1; ready_i = 1'b1;
        @(negedge clk_i);
        valid_i = 1'b0;
        @(negedge clk_i);
        #1;
        check({tag, ".a.valid"}, 64'(valid_a), 1);
        check({tag, ".a.data"}, 64'(data_a), ea);
        check({tag, ".a.ovf"}, 64'(ovf_a), 64'(oa));
        check({tag, ".b.data"}, 64'(data_b), eb);
        check({tag, ".b.ovf"}, 64'(ovf_b), 64'(ob));
        if (chkc) begin
            check({tag, ".c.data"}, 64'(data_c), ec);
            check({tag, ".c.ovf"}, 64'(ovf_c), 0);
        end
    endtask

    initial begin
        int pat [4] = '{1, 0, 0, 1};
        int sent, recv, stab_err, rdy_err, extra, stale;
        bit held_v;
        logic signed [15:0] held_d;

        rst_i = 1'b1; valid_i = 1'b0; data_i = '0; mode_i = 2'd0; ready_i = 1'b1; clr_i = 1'b0;
        #12;
        check("rst.valid", 64'(valid_a), 0);
        check("rst.data", 64'(data_a), 0);
        check("rst.ovf", 64'(ovf_a), 0);
        check("rst.cnt", 64'(cnt_a), 0);
        @(negedge clk_i);
        rst_i = 1'b0;

        // Rounding on +2.5, +3.5, -2.5, -1.25 LSB
        run_beat("pos25.m0", mk(5, 37), 2'd0, 2, 0, 2, 0, 1, 2);
        run_beat("pos25.m1", mk(5, 37), 2'd1, 3, 0, 3, 0, 1, 3);
        run_beat("pos25.m2", mk(5, 37), 2'd2, 2, 0, 2, 0, 1, 2);
        run_beat("pos25.m3", mk(5, 37), 2'd3, 3, 0, 3, 0, 1, 3);
        run_beat("pos35.m2", mk(7, 37), 2'd2, 4, 0, 4, 0, 1, 4);
        run_beat("neg25.m0", mk(-5, 37), 2'd0, -3, 0, -3, 0, 1, -3);
        run_beat("neg25.m1", mk(-5, 37), 2'd1, -2, 0, -2, 0, 1, -2);
        run_beat("neg25.m2", mk(-5, 37), 2'd2, -2, 0, -2, 0, 1, -2);
        run_beat("neg25.m3", mk(-5, 37), 2'd3, -3, 0, -3, 0, 1, -3);
        run_beat("neg125.m3", mk(-5, 36), 2'd3, -1, 0, -1, 0, 1, -1);

        // Extremes of the 53-bit default build: never overflows
        run_beat("max53.m1", 56'((64'sd1 <<< 52) - 64'sd1), 2'd1, 16384, 0, 16384, 0, 1, 16384);
        run_beat("min53.m0", mk(-1, 52), 2'd0, -16384, 0, -16384, 0, 1, -16384);

        // Saturation vs wrap
        run_beat("sat.pos", mk(40000, 38), 2'd0, 32767, 1, -25536, 1, 0, 0);
        run_beat("sat.neg", mk(-40000, 38), 2'd0, -32768, 1, 25536, 1, 0, 0);
        run_beat("sat.rnd", mk(65535, 37), 2'd1, 32767, 1, -32768, 1, 0, 0);
        @(negedge clk_i); #1;
        check("cnt.three.a", 64'(cnt_a), 3);
        check("cnt.three.b", 64'(cnt_b), 3);

        run_beat("sat.pos2", mk(40000, 38), 2'd0, 32767, 1, -25536, 1, 0, 0);
        run_beat("sat.pos3", mk(40000, 38), 2'd0, 32767, 1, -25536, 1, 0, 0);
        @(negedge clk_i); #1;
        check("cnt.five.a", 64'(cnt_a), 5);
        check("cnt.stick.b", 64'(cnt_b), 3);

        // Clear coinciding with a counted event leaves 1
        run_beat("sat.clr", mk(40000, 38), 2'd0, 32767, 1, -25536, 1, 0, 0);
        clr_i = 1'b1;
        @(negedge clk_i);
        clr_i = 1'b0;
        #1;
        check("cnt.clr_evt.a", 64'(cnt_a), 1);
        check("cnt.clr_evt.b", 64'(cnt_b), 1);

        // Back-to-back beats with a mode change per beat
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            ready_i = 1'b1;
            if (i < 4) begin
                valid_i = 1'b1; data_i = mk(5, 37); mode_i = 2'(i);
            end else begin
                valid_i = 1'b0;
            end
            #1;
            if (i == 1) check("tp.latency", 64'(valid_a), 0);
            if (i >= 2) begin
                check($sformatf("tp.v%0d", i - 2), 64'(valid_a), 1);
                check($sformatf("tp.d%0d", i - 2), 64'(data_a), (i - 2) % 2 == 0 ? 2 : 3);
            end
        end
        @(negedge clk_i);
        valid_i = 1'b0; ready_i = 1'b1;

        // Backpressure stream: ready pattern 1,0,0,1 repeating
        sent = 0; recv = 0; stab_err = 0; rdy_err = 0; held_v = 1'b0; held_d = '0;
        for (int c = 0; c < 200 && recv < 10; c++) begin
            @(negedge clk_i);
            ready_i = pat[c % 4] != 0;
            valid_i = sent < 10;
            data_i  = mk(longint'(101 + sent), 38);
            mode_i  = 2'd0;
            #1;
            if (held_v && data_a !== held_d) stab_err++;
            if (ready_a !== (!valid_a || ready_i)) rdy_err++;
            if (valid_a && ready_i) begin
                check($sformatf("bp.d%0d", recv), 64'(data_a), 101 + recv);
                recv++;
            end
            if (valid_i && ready_a) sent++;
            held_v = valid_a && !ready_i;
            held_d = data_a;
        end
        check("bp.recv", recv, 10);
        check("bp.stable", stab_err, 0);
        check("bp.ready", rdy_err, 0);
        valid_i = 1'b0; ready_i = 1'b1;
        extra = 0;
        repeat (4) begin
            @(negedge clk_i); #1;
            if (valid_a) extra++;
        end
        check("bp.extra", extra, 0);

        // Asynchronous reset with two beats in flight and output stalled
        @(negedge clk_i);
        ready_i = 1'b0; valid_i = 1'b1; data_i = mk(7, 38); mode_i = 2'd0;
        @(negedge clk_i);
        data_i = mk(8, 38);
        @(negedge clk_i);
        valid_i = 1'b0;
        #1;
        check("rst2.pre_valid", 64'(valid_a), 1);
        #2;
        rst_i = 1'b1;
        #1;
        check("rst2.valid", 64'(valid_a), 0);
        check("rst2.data", 64'(data_a), 0);
        check("rst2.cnt.a", 64'(cnt_a), 0);
        check("rst2.cnt.b", 64'(cnt_b), 0);
        @(negedge clk_i);
        rst_i = 1'b0; ready_i = 1'b1;
        stale = 0;
        repeat (4) begin
            @(negedge clk_i); #1;
            if (valid_a || valid_b || valid_c) stale++;
        end
        check("rst2.stale", stale, 0);
        run_beat("rst2.new", mk(9, 38), 2'd0, 9, 0, 9, 0, 1, 9);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
